tpu_stream_loader: RTL and testbench

TPU_STREAM_LOADER -- requirements
Module: tpu_stream_loader

---
 rtl/tpu_loader_pkg.sv | 25 ++
 rtl/loader_fifo.sv | 78 +++++++
 rtl/tpu_stream_loader.sv | 230 +++++++++++++++++++++++
 tb/tb_tpu_stream_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_loader_pkg.sv
// rtl/tpu_loader_pkg.sv - shared types and AXI constants for the TPU stream loader
package tpu_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ADDR,
        DATA,
        RESP,
        DONE
    } loader_state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B     = 3'd3;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/loader_fifo.sv
// rtl/loader_fifo.sv - synchronous staging FIFO with occupancy count
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_flush          drop all contents (takes priority over push/pop)
//   i_push, i_data   write side; ignored when full
//   i_pop            read side; ignored when empty
//   o_data           head-of-queue data (valid while !o_empty)
//   o_count          entries held, 0..DEPTH
//   o_full, o_empty  occupancy flags
module loader_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tpu_stream_loader.sv
// rtl/tpu_stream_loader.sv - stream-to-AXI4 burst writer into TPU MMIO space
//
// Buffers a full burst from the input stream, then issues one AXI4 INCR
// write burst at a time and waits for its response before the next.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, cfg_addr, cfg_beats       transfer request (sampled only when idle)
//   busy, done, err                  status: in progress, completion pulse, sticky error
//   s_tdata/s_tvalid/s_tready        input beat stream
//   m_axi_aw*                        write address channel (awid/awsize/awburst fixed)
//   m_axi_w*                         write data channel (wstrb fixed all-ones)
//   m_axi_b*                         write response channel
//
// Build option: define TPU_LOADER_4K_SPLIT_EN to keep bursts inside 4 KB pages.
module tpu_stream_loader
    import tpu_loader_pkg::*;
#(
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] cfg_addr,
    input  logic [15:0] cfg_beats,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [63:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [3:0]  m_axi_awid,
    output logic [63:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [63:0] m_axi_wdata,
    output logic [7:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    loader_state_e r_state;
    logic [63:0]   r_addr;
    logic [15:0]   r_remaining;     // beats not yet acknowledged by B
    logic [15:0]   r_accept_left;   // beats not yet taken from the stream
    logic [8:0]    r_len;           // current burst length in beats
    logic [8:0]    r_beat;          // W beats sent in current burst
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_awvalid;
    logic          r_bready;
    logic [63:0]   r_awaddr;
    logic [7:0]    r_awlen;

    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [63:0]   w_fifo_data;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_fill_phase;
    logic          w_wvalid;
    logic [8:0]    w_rem_clamp;
    logic [8:0]    w_burst_len;

    assign m_axi_awid    = 4'd0;
    assign m_axi_awsize  = AXI_SIZE_8B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wstrb   = 8'hFF;

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_bready  = r_bready;

    // Streaming continues through every active state so the next burst
    // can be staged while the current one is in flight.
    assign w_fill_phase = (r_state == FILL) || (r_state == ADDR) ||
                          (r_state == DATA) || (r_state == RESP);
    assign s_tready     = w_fill_phase && !w_fifo_full && (r_accept_left != 16'd0);
    assign w_push       = s_tvalid && s_tready;

    assign w_wvalid     = (r_state == DATA) && !w_fifo_empty;
    assign m_axi_wvalid = w_wvalid;
    assign m_axi_wdata  = w_wvalid ? w_fifo_data : 64'd0;
    assign m_axi_wlast  = w_wvalid && (r_beat == r_len - 9'd1);
    assign w_pop        = w_wvalid && m_axi_wready;

    assign w_flush      = r_bready && m_axi_bvalid && resp_is_error(m_axi_bresp);

    assign w_rem_clamp  = (r_remaining > 16'(MAX_BURST)) ? 9'(MAX_BURST) : r_remaining[8:0];

`ifdef TPU_LOADER_4K_SPLIT_EN
    // Beats left before the next 4 KB page: 512 minus the beat index in the page.
    logic [9:0] w_4k_beats;
    assign w_4k_beats  = 10'd512 - {1'b0, r_addr[11:3]};
    assign w_burst_len = ({1'b0, w_rem_clamp} > w_4k_beats) ? w_4k_beats[8:0] : w_rem_clamp;
`else
    assign w_burst_len = w_rem_clamp;
`endif

    loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (s_tdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_accept_left <= '0;
            r_len         <= '0;
            r_beat        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_awvalid     <= 1'b0;
            r_bready      <= 1'b0;
            r_awaddr      <= '0;
            r_awlen       <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_push) begin
                r_accept_left <= r_accept_left - 16'd1;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_err <= 1'b0;
                        if (cfg_beats != 16'd0) begin
                            r_addr        <= cfg_addr;
                            r_remaining   <= cfg_beats;
                            r_accept_left <= cfg_beats;
                            r_busy        <= 1'b1;
                            r_state       <= FILL;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    // AW goes out only once the whole burst is already buffered.
                    if (16'(w_fifo_count) >= 16'(w_burst_len)) begin
                        r_len     <= w_burst_len;
                        r_awaddr  <= r_addr;
                        r_awlen   <= 8'(w_burst_len - 9'd1);
                        r_awvalid <= 1'b1;
                        r_state   <= ADDR;
                    end
                end

                ADDR: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= DATA;
                    end
                end

                DATA: begin
                    if (w_pop) begin
                        r_beat <= r_beat + 9'd1;
                        if (m_axi_wlast) begin
                            r_bready <= 1'b1;
                            r_state  <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (resp_is_error(m_axi_bresp)) begin
                            r_err         <= 1'b1;
                            r_accept_left <= '0;
                            r_done        <= 1'b1;
                            r_state       <= DONE;
                        end else begin
                            r_addr      <= r_addr + {52'd0, r_len, 3'b000};
                            r_remaining <= r_remaining - {7'd0, r_len};
                            if (r_remaining == {7'd0, r_len}) begin
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_state <= FILL;
                            end
                        end
                    end
                end

                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_stream_loader.sv
// tb/tb_tpu_stream_loader.sv - directed self-checking bench for tpu_stream_loader
module tb_tpu_stream_loader;
    import tpu_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] cfg_addr;
    logic [15:0] cfg_beats;
    logic        busy, done, err;
    logic [63:0] s_tdata;
    logic        s_tvalid, s_tready;
    logic [3:0]  m_axi_awid;
    logic [63:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;

    always #5 clk = ~clk;

    tpu_stream_loader #(.MAX_BURST(16), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_addr(cfg_addr), .cfg_beats(cfg_beats),
        .busy(busy), .done(done), .err(err),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    int checks = 0;
    int failures = 0;

    int random_mode, err_b, exok_b, xfer_id;
    int src_idx, b_count, done_count, aw_count, w_count, cycle, b_cycle, done_cycle;
    bit b_pending;
    logic [63:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [63:0] w_data_q[$];
    int          wlast_idx_q[$];
    bit          prev_aw_stall, prev_w_stall;
    logic [63:0] prev_awaddr, prev_wdata;
    logic [7:0]  prev_awlen;
    logic        prev_wlast;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pattern(input int k);
        return {16'hC0DE, 16'(xfer_id), 32'(k)};
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_tready"}, s_tready, 0);
        check({tag, "_awvalid"}, m_axi_awvalid, 0);
        check({tag, "_wvalid"}, m_axi_wvalid, 0);
        check({tag, "_bready"}, m_axi_bready, 0);
        check({tag, "_awaddr"}, m_axi_awaddr, 0);
        check({tag, "_awlen"}, m_axi_awlen, 0);
        check({tag, "_wdata"}, m_axi_wdata, 0);
        check({tag, "_wlast"}, m_axi_wlast, 0);
    endtask

    // One clock of bus-functional activity: sample at the falling edge,
    // drive inputs for the next rising edge, log the handshakes it will see.
    task automatic step();
        @(negedge clk);
        cycle++;
        if (prev_aw_stall) begin
            check("aw_hold_valid", m_axi_awvalid, 1);
            check("aw_hold_addr", m_axi_awaddr, prev_awaddr);
            check("aw_hold_len", m_axi_awlen, prev_awlen);
        end
        if (prev_w_stall) begin
            check("w_hold_valid", m_axi_wvalid, 1);
            check("w_hold_data", m_axi_wdata, prev_wdata);
            check("w_hold_last", m_axi_wlast, prev_wlast);
        end
        if (done) begin
            done_count++;
            done_cycle = cycle;
        end
        m_axi_awready = random_mode != 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi_wready  = random_mode != 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_tvalid      = random_mode != 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_tdata       = pattern(src_idx);
        m_axi_bvalid  = b_pending;
        m_axi_bresp   = (b_count == err_b) ? AXI_RESP_SLVERR :
                        (b_count == exok_b) ? AXI_RESP_EXOKAY : AXI_RESP_OKAY;
        if (m_axi_awvalid && m_axi_awready) begin
            aw_addr_q.push_back(m_axi_awaddr);
            aw_len_q.push_back(m_axi_awlen);
            aw_count++;
        end
        prev_aw_stall = m_axi_awvalid && !m_axi_awready;
        prev_awaddr   = m_axi_awaddr;
        prev_awlen    = m_axi_awlen;
        if (m_axi_bvalid && m_axi_bready) begin
            b_pending = 1'b0;
            b_count++;
            b_cycle = cycle;
        end
        if (m_axi_wvalid && m_axi_wready) begin
            w_data_q.push_back(m_axi_wdata);
            if (m_axi_wlast) begin
                wlast_idx_q.push_back(w_count);
                b_pending = 1'b1;
            end
            w_count++;
        end
        prev_w_stall = m_axi_wvalid && !m_axi_wready;
        prev_wdata   = m_axi_wdata;
        prev_wlast   = m_axi_wlast;
        if (s_tvalid && s_tready) src_idx++;
    endtask

    task automatic clear_log();
        aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); wlast_idx_q.delete();
        src_idx = 0; b_count = 0; done_count = 0; aw_count = 0; w_count = 0;
        b_pending = 1'b0; prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
        b_cycle = -100; done_cycle = 0;
        xfer_id++;
    endtask

    task automatic issue_start(input logic [63:0] addr, input int beats);
        step();
        start = 1'b1; cfg_addr = addr; cfg_beats = 16'(beats);
        step();
        start = 1'b0;
    endtask

    task automatic run_xfer(input logic [63:0] addr, input int beats);
        clear_log();
        issue_start(addr, beats);
        for (int i = 0; i < 3000 && done_count == 0; i++) step();
        check("done_seen", done_count, 1);
        check("b_to_done_latency", done_cycle - b_cycle, 1);
        step();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("done_count_final", done_count, 1);
    endtask

    task automatic check_data();
        check("w_beats", w_data_q.size(), w_count);
        foreach (w_data_q[k]) check("wdata_order", w_data_q[k], pattern(k));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_addr = '0; cfg_beats = '0;
        s_tdata = '0; s_tvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        random_mode = 0; err_b = -1; exok_b = -1; xfer_id = 0; cycle = 0;
        clear_log();

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        check("awid", m_axi_awid, 0);
        check("awsize", m_axi_awsize, 3);
        check("awburst", m_axi_awburst, AXI_BURST_INCR);
        check("wstrb", m_axi_wstrb, 8'hFF);
        rst_n = 1'b1;

        // Basic: two full bursts
        run_xfer(64'h1000, 32);
        check("basic_aw_count", aw_count, 2);
        check("basic_awaddr0", aw_addr_q[0], 64'h1000);
        check("basic_awaddr1", aw_addr_q[1], 64'h1080);
        check("basic_awlen0", aw_len_q[0], 15);
        check("basic_awlen1", aw_len_q[1], 15);
        check("basic_w_count", w_count, 32);
        check("basic_wlast_n", wlast_idx_q.size(), 2);
        check("basic_wlast0", wlast_idx_q[0], 15);
        check("basic_wlast1", wlast_idx_q[1], 31);
        check("basic_err", err, 0);
        check("basic_accepted", src_idx, 32);
        check_data();

        // Zero-beat start: done next cycle, no transfer
        clear_log();
        issue_start(64'h1000, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        step();
        check("zero_done_clear", done, 0);
        check("zero_aw_count", aw_count, 0);
        check("zero_accepted", src_idx, 0);

        // Odd tail, first response EXOKAY
        exok_b = 0;
        run_xfer(64'h2000, 20);
        exok_b = -1;
        check("tail_aw_count", aw_count, 2);
        check("tail_awaddr0", aw_addr_q[0], 64'h2000);
        check("tail_awaddr1", aw_addr_q[1], 64'h2080);
        check("tail_awlen0", aw_len_q[0], 15);
        check("tail_awlen1", aw_len_q[1], 3);
        check("tail_wlast0", wlast_idx_q[0], 15);
        check("tail_wlast1", wlast_idx_q[1], 19);
        check("tail_err", err, 0);
        check("tail_accepted", src_idx, 20);
        check_data();

        // 4 KB boundary
        run_xfer(64'hFC0, 16);
`ifdef TPU_LOADER_4K_SPLIT_EN
        check("4k_aw_count", aw_count, 2);
        check("4k_awaddr0", aw_addr_q[0], 64'hFC0);
        check("4k_awlen0", aw_len_q[0], 7);
        check("4k_awaddr1", aw_addr_q[1], 64'h1000);
        check("4k_awlen1", aw_len_q[1], 7);
`else
        check("4k_aw_count", aw_count, 1);
        check("4k_awaddr0", aw_addr_q[0], 64'hFC0);
        check("4k_awlen0", aw_len_q[0], 15);
`endif
        check("4k_accepted", src_idx, 16);
        check_data();

        // Error on second response
        err_b = 1;
        run_xfer(64'h3000, 48);
        err_b = -1;
        check("err_flag", err, 1);
        check("err_aw_count", aw_count, 2);
        check("err_w_count", w_count, 32);
        for (int i = 0; i < 6; i++) begin
            step();
            check("err_tready_low", s_tready, 0);
            check("err_awvalid_low", m_axi_awvalid, 0);
        end
        check("err_no_third_aw", aw_count, 2);
        check("err_sticky", err, 1);
        check_data();

        // Backpressure on every channel
        random_mode = 1;
        run_xfer(64'h4000, 40);
        random_mode = 0;
        check("bp_err_cleared", err, 0);
        check("bp_aw_count", aw_count, 3);
        check("bp_awaddr0", aw_addr_q[0], 64'h4000);
        check("bp_awaddr1", aw_addr_q[1], 64'h4080);
        check("bp_awaddr2", aw_addr_q[2], 64'h4100);
        check("bp_awlen0", aw_len_q[0], 15);
        check("bp_awlen1", aw_len_q[1], 15);
        check("bp_awlen2", aw_len_q[2], 7);
        check("bp_w_count", w_count, 40);
        check("bp_accepted", src_idx, 40);
        check_data();

        // Reset while the fifth W beat is on the bus
        clear_log();
        issue_start(64'h5000, 16);
        for (int i = 0; i < 500 && w_count < 5; i++) step();
        check("rst_reached_beat5", w_count, 5);
        rst_n = 1'b0;
        start = 1'b0; s_tvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        #1;
        check_outputs_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst_no_done", done, 0);
            check("postrst_idle", busy, 0);
        end

        run_xfer(64'h6000, 8);
        check("rerun_aw_count", aw_count, 1);
        check("rerun_awaddr", aw_addr_q[0], 64'h6000);
        check("rerun_awlen", aw_len_q[0], 7);
        check("rerun_wlast", wlast_idx_q[0], 7);
        check("rerun_accepted", src_idx, 8);
        check("rerun_err", err, 0);
        check_data();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
